// File: rtl/axi4_lite_cmd_master.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : axi4_lite_cmd_master                                          |
// | Purpose  : Single-outstanding AXI4-Lite master. Turns a valid/ready      |
// |            command stream (one read or write per command) into AXI4-Lite |
// |            channel handshakes and returns one response beat per command. |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module axi4_lite_cmd_master #(
  parameter int ADDRESS_SIZE = 32,
  parameter int DATA_SIZE    = 32
) (
  input  logic                      aclk,
  input  logic                      areset,
  // command stream
  input  logic                      cmd_valid_i,
  output logic                      cmd_ready_o,
  input  logic                      cmd_write_i,
  input  logic [ADDRESS_SIZE-1:0]   cmd_addr_i,
  input  logic [DATA_SIZE-1:0]      cmd_wdata_i,
  input  logic [DATA_SIZE/8-1:0]    cmd_wstrb_i,
  // response stream
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic                      rsp_write_o,
  output logic [DATA_SIZE-1:0]      rsp_rdata_o,
  output logic [1:0]                rsp_resp_o,
  // AXI4-Lite write address channel
  output logic [ADDRESS_SIZE-1:0]   m_axi_awaddr,
  output logic                      m_axi_awvalid,
  input  logic                      m_axi_awready,
  // AXI4-Lite write data channel
  output logic [DATA_SIZE-1:0]      m_axi_wdata,
  output logic [DATA_SIZE/8-1:0]    m_axi_wstrb,
  output logic                      m_axi_wvalid,
  input  logic                      m_axi_wready,
  // AXI4-Lite write response channel
  input  logic [1:0]                m_axi_bresp,
  input  logic                      m_axi_bvalid,
  output logic                      m_axi_bready,
  // AXI4-Lite read address channel
  output logic [ADDRESS_SIZE-1:0]   m_axi_araddr,
  output logic                      m_axi_arvalid,
  input  logic                      m_axi_arready,
  // AXI4-Lite read data channel
  input  logic [DATA_SIZE-1:0]      m_axi_rdata,
  input  logic [1:0]                m_axi_rresp,
  input  logic                      m_axi_rvalid,
  output logic                      m_axi_rready
);

  localparam int c_STRB_W = DATA_SIZE / 8;

  localparam logic [2:0] c_IDLE    = 3'd0;
  localparam logic [2:0] c_WR_REQ  = 3'd1;
  localparam logic [2:0] c_WR_RESP = 3'd2;
  localparam logic [2:0] c_RD_REQ  = 3'd3;
  localparam logic [2:0] c_RD_DATA = 3'd4;
  localparam logic [2:0] c_RSP     = 3'd5;

  logic [2:0]              r_state;
  logic                    r_cmd_ready;
  logic                    r_awvalid;
  logic                    r_wvalid;
  logic                    r_bready;
  logic                    r_arvalid;
  logic                    r_rready;
  logic                    r_rsp_valid;

  logic [ADDRESS_SIZE-1:0] r_awaddr;
  logic [DATA_SIZE-1:0]    r_wdata;
  logic [c_STRB_W-1:0]     r_wstrb;
  logic [ADDRESS_SIZE-1:0] r_araddr;
  logic                    r_rsp_write;
  logic [DATA_SIZE-1:0]    r_rsp_rdata;
  logic [1:0]              r_rsp_resp;

  logic                    w_cmd_fire;
  logic                    w_aw_done;
  logic                    w_w_done;
  logic                    w_b_fire;
  logic                    w_r_fire;
  logic                    w_rsp_fire;

  // Handshake qualifiers; every term is a registered output gated by an input,
  // used only to decide the next registered state.
  assign w_cmd_fire = cmd_valid_i & r_cmd_ready;
  assign w_aw_done  = ~r_awvalid | m_axi_awready;
  assign w_w_done   = ~r_wvalid  | m_axi_wready;
  assign w_b_fire   = r_bready   & m_axi_bvalid;
  assign w_r_fire   = r_rready   & m_axi_rvalid;
  assign w_rsp_fire = r_rsp_valid & rsp_ready_i;

  // Control FSM: sequences channel valids/readies for one command at a time.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state     <= c_IDLE;
      r_cmd_ready <= 1'b0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_bready    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_rsp_valid <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          r_cmd_ready <= 1'b1;
          if (w_cmd_fire) begin
            r_cmd_ready <= 1'b0;
            if (cmd_write_i) begin
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_state   <= c_WR_REQ;
            end else begin
              r_arvalid <= 1'b1;
              r_state   <= c_RD_REQ;
            end
          end
        end
        c_WR_REQ: begin
          // AW and W retire independently; leave once both have been taken.
          if (r_awvalid && m_axi_awready) r_awvalid <= 1'b0;
          if (r_wvalid && m_axi_wready)   r_wvalid  <= 1'b0;
          if (w_aw_done && w_w_done) begin
            r_bready <= 1'b1;
            r_state  <= c_WR_RESP;
          end
        end
        c_WR_RESP: begin
          if (w_b_fire) begin
            r_bready    <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_state     <= c_RSP;
          end
        end
        c_RD_REQ: begin
          if (m_axi_arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= c_RD_DATA;
          end
        end
        c_RD_DATA: begin
          if (w_r_fire) begin
            r_rready    <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_state     <= c_RSP;
          end
        end
        c_RSP: begin
          if (w_rsp_fire) begin
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= c_IDLE;
          end
        end
        default: begin
          r_state     <= c_IDLE;
          r_cmd_ready <= 1'b0;
          r_awvalid   <= 1'b0;
          r_wvalid    <= 1'b0;
          r_bready    <= 1'b0;
          r_arvalid   <= 1'b0;
          r_rready    <= 1'b0;
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  // Payload capture: command fields on acceptance, response fields on B/R beat.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_awaddr    <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_araddr    <= '0;
      r_rsp_write <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_resp  <= 2'b00;
    end else begin
      if (w_cmd_fire && cmd_write_i) begin
        r_awaddr <= cmd_addr_i;
        r_wdata  <= cmd_wdata_i;
        r_wstrb  <= cmd_wstrb_i;
      end
      if (w_cmd_fire && !cmd_write_i) begin
        r_araddr <= cmd_addr_i;
      end
      if (w_b_fire) begin
        r_rsp_write <= 1'b1;
        r_rsp_rdata <= '0;
        r_rsp_resp  <= m_axi_bresp;
      end else if (w_r_fire) begin
        r_rsp_write <= 1'b0;
        r_rsp_rdata <= m_axi_rdata;
        r_rsp_resp  <= m_axi_rresp;
      end
    end
  end

  assign cmd_ready_o   = r_cmd_ready;
  assign rsp_valid_o   = r_rsp_valid;
  assign rsp_write_o   = r_rsp_write;
  assign rsp_rdata_o   = r_rsp_rdata;
  assign rsp_resp_o    = r_rsp_resp;
  assign m_axi_awaddr  = r_awaddr;
  assign m_axi_awvalid = r_awvalid;
  assign m_axi_wdata   = r_wdata;
  assign m_axi_wstrb   = r_wstrb;
  assign m_axi_wvalid  = r_wvalid;
  assign m_axi_bready  = r_bready;
  assign m_axi_araddr  = r_araddr;
  assign m_axi_arvalid = r_arvalid;
  assign m_axi_rready  = r_rready;

endmodule
`default_nettype wire

// File: tb/tb_axi4_lite_cmd_master.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_axi4_lite_cmd_master                                       |
// | Purpose  : Self-checking bench: randomized slave timing, scoreboard of   |
// |            expected responses and a word-array reference memory.        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_axi4_lite_cmd_master;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        cmd_valid_i = 1'b0, cmd_ready_o, cmd_write_i = 1'b0;
  logic [31:0] cmd_addr_i = '0, cmd_wdata_i = '0;
  logic [3:0]  cmd_wstrb_i = '0;
  logic        rsp_valid_o, rsp_ready_i = 1'b0, rsp_write_o;
  logic [31:0] rsp_rdata_o;
  logic [1:0]  rsp_resp_o;
  logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr;
  logic [31:0] m_axi_rdata = '0;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready;
  logic        m_axi_awready = 1'b0, m_axi_wready = 1'b0, m_axi_bvalid = 1'b0;
  logic        m_axi_arready = 1'b0, m_axi_rvalid = 1'b0;
  logic [1:0]  m_axi_bresp = 2'b00, m_axi_rresp = 2'b00;

  axi4_lite_cmd_master #(.ADDRESS_SIZE(32), .DATA_SIZE(32)) dut (
    .aclk(aclk), .areset(areset),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
    .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i), .cmd_wstrb_i(cmd_wstrb_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_write_o(rsp_write_o),
    .rsp_rdata_o(rsp_rdata_o), .rsp_resp_o(rsp_resp_o),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } cmd_t;

  int   checks = 0;
  int   failures = 0;
  cmd_t sb_q[$];
  cmd_t mon_c;

  logic [31:0] ref_mem [0:127];
  logic [31:0] slv_mem [0:127];

  // Slave environment state
  int   max_dly = 0;
  bit   hold_aw = 1'b0, hold_w = 1'b0, rsp_hold = 1'b0, rsp_rand = 1'b0;
  int   aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0;
  int   aw_beats = 0, w_beats = 0, b_beats = 0, cyc = 0, aw_cyc = 0, w_cyc = 0;
  logic h_aw, h_w, h_b, h_ar, h_r;
  logic [31:0] s_awaddr, s_wdata, s_araddr;
  logic [3:0]  s_wstrb;
  logic aw_got = 1'b0, w_got = 1'b0, b_pend = 1'b0, ar_got = 1'b0;
  logic [31:0] aw_addr = '0, w_data = '0, ar_addr = '0;
  logic [3:0]  w_strb = '0;

  // Monitor state
  logic        p_aw, p_w, p_ar, p_rsp;
  logic [31:0] p_awaddr, p_wdata, p_araddr, p_rdata;
  logic [3:0]  p_wstrb;
  logic        p_write;
  logic [1:0]  p_resp;
  logic [31:0] last_rdata;
  logic [1:0]  last_resp;
  logic        last_write;
  logic [31:0] exp_data;
  logic [1:0]  exp_resp;
  int          rsp_seen = 0;

  function automatic logic [1:0] region_resp(input logic [31:0] a);
    return a[8] ? 2'b10 : 2'b00;
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w, input logic [31:0] new_w,
                                              input logic [3:0] strb);
    logic [31:0] res;
    res = old_w;
    for (int b = 0; b < 4; b++) if (strb[b]) res[8*b +: 8] = new_w[8*b +: 8];
    return res;
  endfunction

  function automatic int rdly();
    if (max_dly <= 0) return 0;
    return int'($urandom_range(32'(max_dly), 32'd0));
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) begin
      ref_mem[i] = '0;
      slv_mem[i] = '0;
    end
  end

  // AXI4-Lite slave model with randomizable ready/valid delays
  initial begin : slave
    forever begin
      @(negedge aclk);
      h_aw = !areset && m_axi_awvalid && m_axi_awready;
      h_w  = !areset && m_axi_wvalid  && m_axi_wready;
      h_b  = !areset && m_axi_bvalid  && m_axi_bready;
      h_ar = !areset && m_axi_arvalid && m_axi_arready;
      h_r  = !areset && m_axi_rvalid  && m_axi_rready;
      s_awaddr = m_axi_awaddr; s_wdata = m_axi_wdata; s_wstrb = m_axi_wstrb;
      s_araddr = m_axi_araddr;
      @(posedge aclk);
      #1;
      cyc++;
      if (areset) begin
        aw_got = 0; w_got = 0; b_pend = 0; ar_got = 0;
        aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
        m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0;
        m_axi_arready = 0; m_axi_rvalid = 0;
      end else begin
        if (h_aw) begin aw_got = 1; aw_addr = s_awaddr; aw_beats++; aw_cyc = cyc; aw_wait = rdly(); end
        if (h_w)  begin w_got = 1; w_data = s_wdata; w_strb = s_wstrb; w_beats++; w_cyc = cyc; w_wait = rdly(); end
        if (h_b)  begin m_axi_bvalid = 0; b_pend = 0; aw_got = 0; w_got = 0; b_beats++; end
        if (aw_got && w_got && !b_pend) begin
          slv_mem[aw_addr[8:2]] = merge_bytes(slv_mem[aw_addr[8:2]], w_data, w_strb);
          b_pend = 1;
          b_wait = rdly();
        end
        if (b_pend && !m_axi_bvalid) begin
          if (b_wait > 0) b_wait--;
          else begin m_axi_bvalid = 1; m_axi_bresp = region_resp(aw_addr); end
        end
        if (h_ar) begin ar_got = 1; ar_addr = s_araddr; r_wait = rdly(); ar_wait = rdly(); end
        if (h_r)  begin m_axi_rvalid = 0; ar_got = 0; end
        if (ar_got && !m_axi_rvalid && !h_r) begin
          if (r_wait > 0) r_wait--;
          else begin
            m_axi_rvalid = 1;
            m_axi_rdata  = slv_mem[ar_addr[8:2]];
            m_axi_rresp  = region_resp(ar_addr);
          end
        end
        m_axi_awready = 0;
        if (m_axi_awvalid && !aw_got && !hold_aw) begin
          if (aw_wait > 0) aw_wait--; else m_axi_awready = 1;
        end
        m_axi_wready = 0;
        if (m_axi_wvalid && !w_got && !hold_w) begin
          if (w_wait > 0) w_wait--; else m_axi_wready = 1;
        end
        m_axi_arready = 0;
        if (m_axi_arvalid && !ar_got) begin
          if (ar_wait > 0) ar_wait--; else m_axi_arready = 1;
        end
      end
    end
  end

  // Response consumer
  initial begin : rsp_driver
    forever begin
      @(posedge aclk);
      #1;
      rsp_ready_i = rsp_hold ? 1'b0 : (rsp_rand ? 1'($urandom_range(1, 0)) : 1'b1);
    end
  end

  // Scoreboard + protocol monitor
  initial begin : monitor
    p_aw = 0; p_w = 0; p_ar = 0; p_rsp = 0;
    forever begin
      @(negedge aclk);
      if (areset) begin
        p_aw = 0; p_w = 0; p_ar = 0; p_rsp = 0;
      end else begin
        if (cmd_valid_i && cmd_ready_o)
          sb_q.push_back('{wr: cmd_write_i, addr: cmd_addr_i, wdata: cmd_wdata_i, strb: cmd_wstrb_i});
        if (rsp_valid_o && rsp_ready_i) begin
          if (sb_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_rsp actual=response required=none");
          end else begin
            mon_c    = sb_q.pop_front();
            exp_resp = region_resp(mon_c.addr);
            if (mon_c.wr) begin
              exp_data = '0;
              ref_mem[mon_c.addr[8:2]] = merge_bytes(ref_mem[mon_c.addr[8:2]], mon_c.wdata, mon_c.strb);
            end else begin
              exp_data = ref_mem[mon_c.addr[8:2]];
            end
            check("rsp_write", 64'(rsp_write_o), 64'(mon_c.wr));
            check("rsp_rdata", 64'(rsp_rdata_o), 64'(exp_data));
            check("rsp_resp",  64'(rsp_resp_o),  64'(exp_resp));
            last_rdata = rsp_rdata_o; last_resp = rsp_resp_o; last_write = rsp_write_o;
            rsp_seen++;
          end
        end
        if (p_aw) check("aw_hold", {31'd0, m_axi_awvalid, m_axi_awaddr}, {31'd0, 1'b1, p_awaddr});
        if (p_w)  check("w_hold", {27'd0, m_axi_wvalid, m_axi_wstrb, m_axi_wdata},
                        {27'd0, 1'b1, p_wstrb, p_wdata});
        if (p_ar) check("ar_hold", {31'd0, m_axi_arvalid, m_axi_araddr}, {31'd0, 1'b1, p_araddr});
        if (p_rsp) check("rsp_hold", {28'd0, rsp_valid_o, rsp_write_o, rsp_resp_o, rsp_rdata_o},
                         {28'd0, 1'b1, p_write, p_resp, p_rdata});
        if (m_axi_bready || m_axi_rready)
          check("ready_excl", 64'({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}), 64'd0);
        p_aw = m_axi_awvalid && !m_axi_awready; p_awaddr = m_axi_awaddr;
        p_w  = m_axi_wvalid && !m_axi_wready;   p_wdata = m_axi_wdata; p_wstrb = m_axi_wstrb;
        p_ar = m_axi_arvalid && !m_axi_arready; p_araddr = m_axi_araddr;
        p_rsp = rsp_valid_o && !rsp_ready_i;
        p_write = rsp_write_o; p_resp = rsp_resp_o; p_rdata = rsp_rdata_o;
      end
    end
  end

  // Hold cmd_valid until accepted (called at posedge+1, returns at posedge+1)
  task automatic wait_accept();
    logic acc;
    int   n;
    acc = 1'b0;
    for (n = 0; n < 500 && !acc; n++) begin
      @(negedge aclk);
      acc = cmd_ready_o;
      @(posedge aclk);
      #1;
    end
    if (!acc) begin
      checks++; failures++;
      $display("FAIL cmd_accept_timeout actual=not_accepted required=accepted");
    end
    cmd_valid_i = 1'b0;
  endtask

  task automatic do_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb);
    cmd_valid_i = 1'b1; cmd_write_i = wr; cmd_addr_i = addr;
    cmd_wdata_i = wdata; cmd_wstrb_i = strb;
    wait_accept();
  endtask

  task automatic drain();
    int n;
    for (n = 0; n < 5000 && (sb_q.size() != 0 || rsp_valid_o); n++) begin
      @(posedge aclk);
      #1;
    end
    if (sb_q.size() != 0) begin
      checks++; failures++;
      $display("FAIL drain_timeout actual=%0d pending required=0", sb_q.size());
    end
  endtask

  int          b0, a0, w0;
  logic [31:0] held_rdata;
  int          n_wait;

  initial begin : main
    // Reset state
    repeat (3) @(negedge aclk);
    check("rst_cmd_ready", 64'(cmd_ready_o), 64'd0);
    check("rst_valids", 64'({rsp_valid_o, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}), 64'd0);
    check("rst_readies", 64'({m_axi_bready, m_axi_rready}), 64'd0);
    check("rst_payload", 64'(m_axi_awaddr | m_axi_wdata | m_axi_araddr | rsp_rdata_o), 64'd0);
    @(posedge aclk); #1;
    areset = 1'b0;
    @(posedge aclk); #1;
    check("cmd_ready_after_rst", 64'(cmd_ready_o), 64'd1);

    // Test 1: write then read back, always-ready slave, latency
    do_cmd(1'b1, 32'h0, 32'hDEADBEEF, 4'hF);
    check("t1_aw_w_valid", 64'({m_axi_awvalid, m_axi_wvalid}), 64'h3);
    check("t1_awaddr", 64'(m_axi_awaddr), 64'h0);
    check("t1_wdata", 64'({m_axi_wstrb, m_axi_wdata}), 64'hF_DEADBEEF);
    @(posedge aclk); #1;
    check("t1_bready", 64'(m_axi_bready), 64'd1);
    @(posedge aclk); #1;
    check("t1_rsp_valid", 64'(rsp_valid_o), 64'd1);
    drain();
    check("t1_wr_rsp", 64'({last_write, last_resp}), 64'({1'b1, 2'b00}));
    do_cmd(1'b0, 32'h0, 32'h0, 4'h0);
    drain();
    check("t1_readback", 64'(last_rdata), 64'hDEADBEEF);

    // Test 2: AW delayed 3 cycles, then W delayed 3 cycles
    a0 = aw_beats; w0 = w_beats; b0 = b_beats;
    aw_wait = 3; w_wait = 0;
    do_cmd(1'b1, 32'h8, 32'hA5A5A5A5, 4'hF);
    drain();
    check("t2_aw_after_w", 64'(aw_cyc - w_cyc), 64'd3);
    check("t2_beats", 64'({8'(aw_beats - a0), 8'(w_beats - w0), 8'(b_beats - b0)}), 64'h010101);
    a0 = aw_beats; w0 = w_beats; b0 = b_beats;
    aw_wait = 0; w_wait = 3;
    do_cmd(1'b1, 32'hC, 32'h5A5A5A5A, 4'h5);
    drain();
    check("t2_w_after_aw", 64'(w_cyc - aw_cyc), 64'd3);
    check("t2r_beats", 64'({8'(aw_beats - a0), 8'(w_beats - w0), 8'(b_beats - b0)}), 64'h010101);

    // Test 3: error region read
    do_cmd(1'b1, 32'h104, 32'h12345678, 4'hF);
    do_cmd(1'b0, 32'h104, 32'h0, 4'h0);
    drain();
    check("t3_read", 64'({last_write, last_resp, last_rdata}), 64'({1'b0, 2'b10, 32'h12345678}));

    // Test 4: response back-pressure with a pending command
    rsp_hold = 1'b1;
    do_cmd(1'b0, 32'h8, 32'h0, 4'h0);
    for (n_wait = 0; n_wait < 100 && !rsp_valid_o; n_wait++) begin
      @(posedge aclk); #1;
    end
    check("t4_rsp_seen", 64'(rsp_valid_o), 64'd1);
    held_rdata  = rsp_rdata_o;
    cmd_valid_i = 1'b1; cmd_write_i = 1'b1; cmd_addr_i = 32'h10;
    cmd_wdata_i = 32'hCAFEF00D; cmd_wstrb_i = 4'b0011;
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      check("t4_cmd_ready_low", 64'(cmd_ready_o), 64'd0);
      check("t4_no_axi_valid", 64'({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}), 64'd0);
      check("t4_rsp_stable", 64'({rsp_valid_o, rsp_rdata_o}), 64'({1'b1, held_rdata}));
    end
    rsp_hold = 1'b0;
    @(posedge aclk); #1;
    wait_accept();
    drain();

    // Test 5: reset during write address phase
    hold_aw = 1'b1; hold_w = 1'b1;
    do_cmd(1'b1, 32'h20, 32'h55AA55AA, 4'hF);
    check("t5_aw_pending", 64'(m_axi_awvalid), 64'd1);
    #2 areset = 1'b1;
    #1;
    check("t5_async_clear", 64'({m_axi_awvalid, m_axi_wvalid, cmd_ready_o, rsp_valid_o}), 64'd0);
    sb_q.delete();
    repeat (2) @(posedge aclk);
    #1;
    areset = 1'b0; hold_aw = 1'b0; hold_w = 1'b0;
    @(posedge aclk); #1;
    check("t5_ready_after", 64'(cmd_ready_o), 64'd1);
    do_cmd(1'b1, 32'h20, 32'h0BADF00D, 4'hF);
    do_cmd(1'b0, 32'h20, 32'h0, 4'h0);
    drain();
    check("t5_readback", 64'(last_rdata), 64'h0BADF00D);

    // Test 6: random traffic against reference memory
    max_dly = 3; rsp_rand = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      logic [31:0] a;
      a = {23'd0, ($urandom_range(7, 0) == 0), 6'($urandom_range(63, 0)), 2'b00};
      repeat ($urandom_range(2, 0)) begin @(posedge aclk); #1; end
      do_cmd(1'($urandom_range(1, 0)), a, $urandom, 4'($urandom_range(15, 0)));
    end
    drain();
    check("t6_all_responses", 64'(sb_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
